// File: rtl/fp8_mul_arbiter.sv
// fp8_mul_arbiter
// Round-robin arbiter and sequencer sharing one FP8 multiplier among NUM_REQ
// requesters. Grants one operand pair per cycle, drives the multiplier issue
// registers, tracks in-flight ops with a tag pipe matched to MUL_LAT, and
// returns each product to the requester that issued it. A granted requester
// with lock set may keep the grant for up to MAX_BURST consecutive transfers.
// Optional build macro FP8_ARB_PERF_EN adds per-requester 16-bit saturating
// grant counters read through perf_sel / perf_cnt.
module fp8_mul_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int W         = 8,
  parameter int MUL_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  input  logic [NUM_REQ*W-1:0]       opa,
  input  logic [NUM_REQ*W-1:0]       opb,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [W-1:0]               mul_a,
  output logic [W-1:0]               mul_b,
  output logic                       mul_vld,
  input  logic [W-1:0]               mul_p,
  output logic [NUM_REQ-1:0]         rsp_vld,
  output logic [W-1:0]               rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       busy
`ifdef FP8_ARB_PERF_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0] perf_sel,
  output logic [15:0]                perf_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {
    S_ARB,
    S_LOCK
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [3:0]    burst_cnt, burst_nxt;

  logic [IW-1:0] gnt_idx;
  logic          xfer;
  logic [W-1:0]  sel_a, sel_b;

  logic [IW-1:0] iss_id;
  logic          ex_vld;
  logic [IW-1:0] ex_id;
  logic          pipe_busy;

  // Next requester index after i, wrapping at NUM_REQ (which need not be a power of two).
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Grant: owner only while locked, otherwise the first request at/after ptr.
  always_comb begin : p_grant
    logic          found;
    logic [IW-1:0] cand;
    int            j;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found   = 1'b0;
    cand    = '0;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    if (!rst && en) begin
      if (state == S_LOCK) begin
        gnt_idx = owner;
        found   = req[owner];
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = int'(ptr) + k;
          if (j >= NUM_REQ) j = j - NUM_REQ;
          cand = IW'(j);
          if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
          end
        end
      end
      gnt[gnt_idx] = found;
    end
  end

  assign xfer = |gnt;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(gnt_idx) == i) begin
        sel_a = opa[i*W +: W];
        sel_b = opb[i*W +: W];
      end
    end
  end

  // FSM next state: ARB/LOCK transitions, pointer update and burst counting.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    burst_nxt = burst_cnt;
    if (!en) begin
      state_nxt = S_ARB;
      burst_nxt = '0;
    end else if (state == S_ARB) begin
      if (xfer) begin
        if (lock[gnt_idx] && (MAX_BURST > 1)) begin
          state_nxt = S_LOCK;
          owner_nxt = gnt_idx;
          burst_nxt = 4'd1;
        end else begin
          ptr_nxt = wrap_inc(gnt_idx);
        end
      end
    end else begin
      // In LOCK with req[owner] high a transfer always happens this cycle.
      if (!req[owner] || !lock[owner] || (burst_cnt + 4'd1 == 4'(MAX_BURST))) begin
        state_nxt = S_ARB;
        burst_nxt = '0;
        ptr_nxt   = wrap_inc(owner);
      end else begin
        burst_nxt = burst_cnt + 4'd1;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= S_ARB;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Issue stage: capture operands and requester id on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_vld <= 1'b0;
      iss_id  <= '0;
    end else begin
      mul_vld <= xfer;
      if (xfer) begin
        mul_a  <= sel_a;
        mul_b  <= sel_b;
        iss_id <= gnt_idx;
      end
    end
  end

  // Tag pipe: {valid, id} delayed by MUL_LAT so it exits alongside mul_p.
  generate
    if (MUL_LAT == 0) begin : g_no_pipe
      assign ex_vld    = mul_vld;
      assign ex_id     = iss_id;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [MUL_LAT-1:0] t_vld;
      logic [IW-1:0]      t_id [MUL_LAT];

      // Shift tags one stage per cycle; only the valid bits are cleared by reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          t_vld <= '0;
        end else begin
          t_vld[0] <= mul_vld;
          for (int s = 1; s < MUL_LAT; s++) t_vld[s] <= t_vld[s-1];
        end
        // NOTE: the id array is not reset; it is only consumed when its valid bit is set.
        t_id[0] <= iss_id;
        for (int s = 1; s < MUL_LAT; s++) t_id[s] <= t_id[s-1];
      end

      assign ex_vld    = t_vld[MUL_LAT-1];
      assign ex_id     = t_id[MUL_LAT-1];
      assign pipe_busy = |t_vld;
    end
  endgenerate

  // Response stage: register the product and route it to the issuing requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld  <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      rsp_vld <= ex_vld ? (NUM_REQ'(1) << ex_id) : '0;
      if (ex_vld) begin
        rsp_data <= mul_p;
        rsp_id   <= ex_id;
      end
    end
  end

  assign busy = mul_vld | pipe_busy;

`ifdef FP8_ARB_PERF_EN
  logic [15:0] perf_q [NUM_REQ];

  // Per-requester saturating grant counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) perf_q[i] <= '0;
      else if (gnt[i] && (perf_q[i] != 16'hFFFF)) perf_q[i] <= perf_q[i] + 16'd1;
    end
  end

  assign perf_cnt = perf_q[perf_sel];
`endif

endmodule
